// File: rtl/leading_zero_counter.sv
// Registered leading-zero count of in_range via a log-depth valid/count merge tree.
// One-cycle latency, new operand every clock, no stall or backpressure.
module leading_zero_counter #(
  parameter int RANGE_WIDTH_LCZ = 16,
  parameter int D_SIZE_LZC      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [RANGE_WIDTH_LCZ-1:0] in_range,
  output logic [D_SIZE_LZC-1:0]      lzc_out,
  output logic                       v
);

  if (((2 ** D_SIZE_LZC) != RANGE_WIDTH_LCZ) || (RANGE_WIDTH_LCZ < 4)) begin : g_param_err
    $error("leading_zero_counter: RANGE_WIDTH_LCZ must be a power of two >= 4 equal to 2**D_SIZE_LZC");
  end

  // Level l holds RANGE_WIDTH_LCZ>>(l+1) nodes, each with an (l+1)-bit count.
  for (genvar l = 0; l < D_SIZE_LZC; l++) begin : g_lvl
    localparam int N  = RANGE_WIDTH_LCZ >> (l + 1);
    localparam int CW = l + 1;

    logic [N-1:0]    vld;
    logic [N*CW-1:0] cnt;

    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < N; i++) begin : g_node
        assign vld[i] = in_range[2*i+1] | in_range[2*i];
        assign cnt[i] = ~in_range[2*i+1];
      end
    end else begin : g_merge
      for (genvar i = 0; i < N; i++) begin : g_node
        logic          v_hi;
        logic          v_lo;
        logic [CW-2:0] c_hi;
        logic [CW-2:0] c_lo;

        assign v_hi = g_lvl[l-1].vld[2*i+1];
        assign v_lo = g_lvl[l-1].vld[2*i];
        assign c_hi = g_lvl[l-1].cnt[(2*i+1)*(CW-1) +: (CW-1)];
        assign c_lo = g_lvl[l-1].cnt[(2*i)*(CW-1) +: (CW-1)];

        assign vld[i]            = v_hi | v_lo;
        assign cnt[i*CW +: CW]   = v_hi ? {1'b0, c_hi} : {1'b1, c_lo};
      end
    end
  end

  logic                  root_v;
  logic [D_SIZE_LZC-1:0] root_cnt;
  logic [D_SIZE_LZC-1:0] lzc_d;
  logic [D_SIZE_LZC-1:0] lzc_q;
  logic                  v_d;
  logic                  v_q;

  assign root_v   = g_lvl[D_SIZE_LZC-1].vld[0];
  assign root_cnt = g_lvl[D_SIZE_LZC-1].cnt[D_SIZE_LZC-1:0];

  // An all-zero operand would walk the tree to all ones; report 0 instead.
  assign v_d   = root_v;
  assign lzc_d = root_v ? root_cnt : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lzc_q <= '0;
      v_q   <= 1'b0;
    end else begin
      lzc_q <= lzc_d;
      v_q   <= v_d;
    end
  end

  assign lzc_out = lzc_q;
  assign v       = v_q;

endmodule

// File: tb/tb_leading_zero_counter.sv
// Scoreboard bench for leading_zero_counter at 16-bit and 32-bit widths.
module tb_leading_zero_counter;

  typedef struct {
    logic [31:0] din;
    int          lzc;
    logic        vld;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] in16 = 16'hFFFF;
  logic [31:0] in32 = 32'hFFFF_FFFF;
  logic [3:0]  lzc16;
  logic [4:0]  lzc32;
  logic        v16;
  logic        v32;

  exp_t q16[$];
  exp_t q32[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  leading_zero_counter #(.RANGE_WIDTH_LCZ(16), .D_SIZE_LZC(4)) dut16 (
    .clk(clk), .reset(reset), .in_range(in16), .lzc_out(lzc16), .v(v16)
  );

  leading_zero_counter #(.RANGE_WIDTH_LCZ(32), .D_SIZE_LZC(5)) dut32 (
    .clk(clk), .reset(reset), .in_range(in32), .lzc_out(lzc32), .v(v32)
  );

  function automatic int ref_lzc(input logic [31:0] x, input int w);
    for (int p = w - 1; p >= 0; p--) begin
      if (x[p]) return w - 1 - p;
    end
    return 0;
  endfunction

  task automatic check(input string name, input logic [31:0] din, input int got_lzc,
                       input logic got_v, input int want_lzc, input logic want_v);
    n_vec++;
    if (got_lzc != want_lzc || got_v !== want_v) begin
      n_err++;
      $display("FAIL %s in=%h got lzc=%0d v=%b want lzc=%0d v=%b",
               name, din, got_lzc, got_v, want_lzc, want_v);
    end
  endtask

  // Drive one operand pair before the next rising edge; lzc_hand is the hand-computed 16-bit count.
  task automatic apply(input logic [15:0] a, input int lzc_hand, input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    in16 = a;
    in32 = b;
    e.din = {16'h0, a};
    e.lzc = lzc_hand;
    e.vld = (a != 16'h0);
    q16.push_back(e);
    e.din = b;
    e.lzc = ref_lzc(b, 32);
    e.vld = (b != 32'h0);
    q32.push_back(e);
  endtask

  task automatic apply_ref(input logic [15:0] a, input logic [31:0] b);
    apply(a, ref_lzc({16'h0, a}, 16), b);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      if (reset) begin
        #1;
        if (q16.size() != 0) begin
          e = q16.pop_front();
          check("lzc16", e.din, int'(lzc16), v16, e.lzc, e.vld);
        end
        if (q32.size() != 0) begin
          e = q32.pop_front();
          check("lzc32", e.din, int'(lzc32), v32, e.lzc, e.vld);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] hand_val [5];
    int          hand_lzc [5];
    hand_val = '{16'h1234, 16'h00FF, 16'h7FFF, 16'h0100, 16'h0003};
    hand_lzc = '{3, 8, 1, 7, 14};

    // Reset held with all-ones input: outputs must stay cleared.
    repeat (3) @(posedge clk);
    #1;
    check("reset16", {16'h0, in16}, int'(lzc16), v16, 0, 1'b0);
    check("reset32", in32, int'(lzc32), v32, 0, 1'b0);

    @(negedge clk);
    reset = 1'b1;
    in16  = 16'h8000;
    in32  = 32'h8000_0000;
    begin
      exp_t e;
      e.din = 32'h8000; e.lzc = 0; e.vld = 1'b1; q16.push_back(e);
      e.din = 32'h8000_0000; e.lzc = 0; e.vld = 1'b1; q32.push_back(e);
    end

    // Walking one, 16-bit with hand counts 0..15; 32-bit walks all 32 positions.
    for (int i = 0; i < 32; i++) begin
      logic [15:0] a;
      logic [31:0] b;
      a = 16'h8000 >> (i % 16);
      b = 32'h8000_0000 >> i;
      apply(a, i % 16, b);
    end

    for (int i = 0; i < 5; i++) apply(hand_val[i], hand_lzc[i], $urandom());

    apply(16'h0000, 0, 32'h0000_0000);
    apply(16'hFFFF, 0, 32'hFFFF_FFFF);
    apply(16'h0000, 0, 32'h0000_0001);
    apply(16'h0001, 15, 32'h0000_0000);

    // Reset mid-stream, asserted between edges.
    for (int i = 0; i < 6; i++) apply_ref(16'($urandom()), $urandom());
    apply(16'h0001, 15, 32'h0000_0001);
    apply(16'h2000, 2, 32'h0000_0003);
    #2;
    reset = 1'b0;
    #1;
    check("midrst16", 32'h2000, int'(lzc16), v16, 0, 1'b0);
    check("midrst32", 32'h3, int'(lzc32), v32, 0, 1'b0);
    q16.delete();
    q32.delete();
    @(posedge clk);
    #1;
    check("rsthold16", 32'h2000, int'(lzc16), v16, 0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    apply(16'h0040, 9, 32'h0040_0000);
    for (int i = 0; i < 8; i++) apply_ref(16'($urandom()), $urandom());

    // Strided sweep of the 16-bit space plus random 32-bit operands.
    for (int k = 0; k < 65536; k += 3) begin
      logic [15:0] a;
      a = k[15:0];
      apply_ref(a, $urandom() >> ($urandom() % 32));
    end
    apply_ref(16'hFFFF, 32'h0000_0000);

    repeat (3) @(negedge clk);
    n_vec++;
    if (q16.size() != 0 || q32.size() != 0) begin
      n_err++;
      $display("FAIL drain got pending=%0d/%0d want 0/0", q16.size(), q32.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/leading_zero_counter.md
Name: leading_zero_counter

Overview:
- Parameterised leading-zero counter for the AV1 arithmetic-encoder renormalisation path.
- Takes the post-encode range value and returns the left-shift count d, i.e. the number of leading zeros, so that (range << d) has its MSB set.
- Also flags whether the input was non-zero.
- Output is registered: one-cycle latency, fully pipelined, accepts a new operand every clock.

Parameters:
- RANGE_WIDTH_LCZ, 16, width of the input operand. Must be a power of two, at least 4.
- D_SIZE_LZC, 4, width of the count output. Must equal log2(RANGE_WIDTH_LCZ).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_range  input  RANGE_WIDTH_LCZ  operand to examine. Bit RANGE_WIDTH_LCZ-1 is the MSB.
- lzc_out  output  D_SIZE_LZC  registered count of consecutive zero bits, starting from the MSB.
- v  output  1  registered valid flag. 1 when the sampled in_range was non-zero.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset).
- Reset (reset=0, asynchronous assert): lzc_out=0 and v=0 immediately, held while reset is low. Deassertion is synchronised to clk by the integrator. The first capture happens on the first rising edge with reset=1.
- Every rising edge with reset=1 captures the combinational result for the current in_range. There is no enable and no stall, so the result of input N appears on the outputs in the cycle after edge N.
- Count rule: lzc_out = RANGE_WIDTH_LCZ-1-p, where p is the index of the highest set bit of in_range. The range is 0 for MSB set up to RANGE_WIDTH_LCZ-1 for only bit 0 set.
- Valid rule: v = OR-reduction of in_range.
- Zero input: v=0 and lzc_out=0. Consumers must ignore lzc_out when v=0; the count never wraps or saturates to all ones.
- Combinational core:
  - Balanced binary tree.
  - Leaves are 2-bit cells producing (valid, 1-bit count).
  - Each merge level takes left (upper) and right (lower) halves:
    - valid = vL | vR.
    - If vL=1, count = {0, cL}.
    - Otherwise count = {1, cR}.
  - The tree has D_SIZE_LZC levels, built with a generate loop so that any legal RANGE_WIDTH_LCZ works without code edits.
  - A flat priority if/case chain is not acceptable; depth must be O(log width).
- No X propagation: every in_range value, including all zeros and all ones, produces defined outputs.
- Reset mid-stream: the in-flight result is discarded and outputs go to 0/0. The first valid output after release corresponds to the in_range sampled at the first post-release edge.
- Parameter check: elaboration-time assertion that 2**D_SIZE_LZC == RANGE_WIDTH_LCZ. Fail compilation otherwise.
- No internal state beyond the output registers. Back-to-back changing inputs each cycle are fully supported.

Test Plan:
- Reset: hold reset=0 with in_range=16'hFFFF -> lzc_out=0, v=0. Release reset with in_range=16'h8000 -> next edge gives lzc_out=0, v=1.
- Walking one: apply 16'h8000, 16'h4000, ..., 16'h0001 on consecutive cycles -> lzc_out = 0, 1, ..., 15 one cycle later each, with v=1 throughout.
- Mixed values:
  - 16'h1234 -> 3.
  - 16'h00FF -> 8.
  - 16'h7FFF -> 1.
  - 16'h0100 -> 7.
  - 16'h0003 -> 14.
  - All with v=1.
- Zero input: in_range=16'h0000 -> v=0 and lzc_out=0. Then 16'hFFFF -> lzc_out=0, v=1 on the next cycle.
- Reset mid-stream: drive random values, assert reset asynchronously between edges -> outputs go to 0 without waiting for a clock edge. After release, outputs match the golden model with one-cycle latency.
- Exhaustive sweep:
  - All 65536 inputs back-to-back against a reference model: highest-set-bit search with latency 1.
  - Repeat with RANGE_WIDTH_LCZ=32, D_SIZE_LZC=5 on random plus walking-one inputs.
